// File: rtl/toy_exec_unit.sv
// rtl/toy_exec_unit.sv - RISC_TOY execute stage: registered ALU, branch evaluation, iterative multiplier
//
// Ports:
//   CLK, RSTN           clock, asynchronous active-low reset
//   FLUSH               synchronous kill of the in-flight multiply and the held result
//   IN_VALID/IN_READY   input handshake; an op is taken when both are high at a rising edge
//   IN_OP, IN_A, IN_B   opcode and operands
//   IN_IMM              immediate, sign-extended to DW
//   IN_COND             branch condition code, evaluated on IN_B for BRCOND
//   IN_TAG              destination tag carried through to OUT_TAG
//   OUT_VALID/OUT_READY output handshake; the result registers hold while stalled
//   OUT_RESULT          result
//   OUT_TAKEN           branch taken (BRCOND only)
//   OUT_ILLEGAL         opcode undefined or disabled
//   OUT_TAG             tag of the result
//   BUSY                multiplier iterating
module toy_exec_unit #(
    parameter int DW     = 32,
    parameter int IMMW   = 17,
    parameter int TAGW   = 5,
    parameter int MUL_EN = 1
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [4:0]      IN_OP,
    input  logic [DW-1:0]   IN_A,
    input  logic [DW-1:0]   IN_B,
    input  logic [IMMW-1:0] IN_IMM,
    input  logic [2:0]      IN_COND,
    input  logic [TAGW-1:0] IN_TAG,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [DW-1:0]   OUT_RESULT,
    output logic            OUT_TAKEN,
    output logic            OUT_ILLEGAL,
    output logic [TAGW-1:0] OUT_TAG,
    output logic            BUSY
);

    localparam int SHW = $clog2(DW);
    localparam int CW  = $clog2(DW + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   acc_q;
    logic [DW-1:0]   mcand_q;
    logic [DW-1:0]   mplier_q;
    logic [TAGW-1:0] mtag_q;
    logic [DW-1:0]   acc_next;

    logic            accept;
    logic            is_mul;
    logic            start_mul;
    logic            load_alu;
    logic            mul_done;

    logic [DW-1:0]   imm_ext;
    logic [SHW-1:0]  sh;
    logic [SHW-1:0]  sh_neg;
    logic [DW-1:0]   alu_res;
    logic            alu_taken;
    logic            alu_illegal;

    // Reset gates IN_READY so nothing is taken while RSTN is low.
    assign IN_READY = RSTN && !FLUSH && (state_q != S_MUL) && (!OUT_VALID || OUT_READY);
    assign accept   = IN_VALID && IN_READY;
    assign is_mul   = (IN_OP == 5'd16) && (MUL_EN != 0);
    assign BUSY     = (state_q == S_MUL);

    assign imm_ext  = DW'($signed(IN_IMM));
    assign sh       = IN_B[SHW-1:0];
    // Rotate right by sh == rotate left by (DW - sh); the negation wraps
    // modulo DW, so sh == 0 ORs A with itself and returns A unchanged.
    assign sh_neg   = SHW'(0) - sh;

    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        alu_res     = '0;
        alu_taken   = 1'b0;
        alu_illegal = 1'b0;
        case (IN_OP)
            5'd0:  alu_res = IN_A + IN_B;
            5'd1:  alu_res = IN_A - IN_B;
            5'd2:  alu_res = '0 - IN_B;
            5'd3:  alu_res = ~IN_B;
            5'd4:  alu_res = IN_A & IN_B;
            5'd5:  alu_res = IN_A | IN_B;
            5'd6:  alu_res = IN_A ^ IN_B;
            5'd7:  alu_res = IN_A >> sh;
            5'd8:  alu_res = $unsigned($signed(IN_A) >>> sh);
            5'd9:  alu_res = IN_A << sh;
            5'd10: alu_res = (IN_A >> sh) | (IN_A << sh_neg);
            5'd11: alu_res = IN_A + imm_ext;
            5'd12: alu_res = IN_A & imm_ext;
            5'd13: alu_res = IN_A | imm_ext;
            5'd14: alu_res = imm_ext;
            5'd15: begin
                alu_res = IN_A;
                case (IN_COND)
                    3'd1:    alu_taken = 1'b1;
                    3'd2:    alu_taken = (IN_B == '0);
                    3'd3:    alu_taken = (IN_B != '0);
                    3'd4:    alu_taken = !IN_B[DW-1];
                    3'd5:    alu_taken = IN_B[DW-1];
                    default: alu_taken = 1'b0;
                endcase
            end
            // Only reaches the output register when the multiplier is disabled.
            5'd16:   alu_illegal = (MUL_EN == 0);
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        start_mul = 1'b0;
        load_alu  = 1'b0;
        mul_done  = 1'b0;
        if (FLUSH) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            start_mul = 1'b1;
                            state_d   = S_MUL;
                        end else begin
                            load_alu = 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    // Counter goes 1 -> 0 on this edge: the DW-th step.
                    if (cnt_q == CW'(1)) begin
                        mul_done = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            OUT_VALID   <= 1'b0;
            OUT_RESULT  <= '0;
            OUT_TAKEN   <= 1'b0;
            OUT_ILLEGAL <= 1'b0;
            OUT_TAG     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mtag_q      <= '0;
        end else if (FLUSH) begin
            OUT_VALID   <= 1'b0;
            OUT_RESULT  <= '0;
            OUT_TAKEN   <= 1'b0;
            OUT_ILLEGAL <= 1'b0;
            OUT_TAG     <= '0;
            cnt_q       <= '0;
        end else begin
            if (load_alu) begin
                OUT_VALID   <= 1'b1;
                OUT_RESULT  <= alu_res;
                OUT_TAKEN   <= alu_taken;
                OUT_ILLEGAL <= alu_illegal;
                OUT_TAG     <= IN_TAG;
            end else if (mul_done) begin
                OUT_VALID   <= 1'b1;
                OUT_RESULT  <= acc_next;
                OUT_TAKEN   <= 1'b0;
                OUT_ILLEGAL <= 1'b0;
                OUT_TAG     <= mtag_q;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            if (start_mul) begin
                acc_q    <= '0;
                mcand_q  <= IN_A;
                mplier_q <= IN_B;
                mtag_q   <= IN_TAG;
                cnt_q    <= CW'(DW);
            end else if (state_q == S_MUL) begin
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_toy_exec_unit.sv
// tb/tb_toy_exec_unit.sv - directed self-checking bench for toy_exec_unit
module tb_toy_exec_unit;

    logic        CLK;
    logic        RSTN;
    logic        FLUSH;
    logic        IN_VALID;
    logic [4:0]  IN_OP;
    logic [31:0] IN_A;
    logic [31:0] IN_B;
    logic [16:0] IN_IMM;
    logic [2:0]  IN_COND;
    logic [4:0]  IN_TAG;
    logic        OUT_READY;

    logic        in_ready, out_valid, out_taken, out_illegal, busy;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    logic        nm_in_ready, nm_out_valid, nm_out_taken, nm_out_illegal, nm_busy;
    logic [31:0] nm_out_result;
    logic [4:0]  nm_out_tag;

    int vectors = 0;
    int miscompares = 0;

    toy_exec_unit #(.DW(32), .IMMW(17), .TAGW(5), .MUL_EN(1)) u_dut (
        .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(in_ready), .IN_OP(IN_OP),
        .IN_A(IN_A), .IN_B(IN_B), .IN_IMM(IN_IMM), .IN_COND(IN_COND), .IN_TAG(IN_TAG),
        .OUT_VALID(out_valid), .OUT_READY(OUT_READY), .OUT_RESULT(out_result),
        .OUT_TAKEN(out_taken), .OUT_ILLEGAL(out_illegal), .OUT_TAG(out_tag), .BUSY(busy)
    );

    toy_exec_unit #(.DW(32), .IMMW(17), .TAGW(5), .MUL_EN(0)) u_nomul (
        .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(nm_in_ready), .IN_OP(IN_OP),
        .IN_A(IN_A), .IN_B(IN_B), .IN_IMM(IN_IMM), .IN_COND(IN_COND), .IN_TAG(IN_TAG),
        .OUT_VALID(nm_out_valid), .OUT_READY(OUT_READY), .OUT_RESULT(nm_out_result),
        .OUT_TAKEN(nm_out_taken), .OUT_ILLEGAL(nm_out_illegal), .OUT_TAG(nm_out_tag), .BUSY(nm_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op and step past the next rising edge; IN_VALID is left high.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [16:0] imm, input logic [2:0] cond, input logic [4:0] tag);
        IN_OP    = op;
        IN_A     = a;
        IN_B     = b;
        IN_IMM   = imm;
        IN_COND  = cond;
        IN_TAG   = tag;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTN = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; IN_OP = '0; IN_A = '0; IN_B = '0;
        IN_IMM = '0; IN_COND = '0; IN_TAG = '0; OUT_READY = 1'b1;
        tick; tick;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        RSTN = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        issue(5'd0, 32'hFFFF_FFFF, 32'd2, '0, '0, 5'd3);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", out_result, 32'h0000_0001);
        chk("add_tag", 32'(out_tag), 32'd3);

        // Back-to-back stream, one result per edge.
        issue(5'd1, 32'd5, 32'd7, '0, '0, 5'd4);
        chk("sub_result", out_result, 32'hFFFF_FFFE);
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_tag", 32'(out_tag), 32'd4);
        issue(5'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, '0, '0, 5'd5);
        chk("xor_result", out_result, 32'h0FF0_0FF0);
        issue(5'd10, 32'h8000_0001, 32'd1, '0, '0, 5'd6);
        chk("ror1_result", out_result, 32'hC000_0000);
        issue(5'd10, 32'h8000_0001, 32'd0, '0, '0, 5'd7);
        chk("ror0_result", out_result, 32'h8000_0001);
        issue(5'd8, 32'h8000_0000, 32'd4, '0, '0, 5'd8);
        chk("asr_result", out_result, 32'hF800_0000);
        issue(5'd11, 32'd10, '0, 17'h1FFFF, '0, 5'd9);
        chk("addi_result", out_result, 32'd9);
        issue(5'd14, '0, '0, 17'h10000, '0, 5'd10);
        chk("movi_result", out_result, 32'hFFFF_0000);
        chk("movi_in_ready", 32'(in_ready), 32'd1);

        issue(5'd15, 32'h100, 32'hFFFF_FFF0, '0, 3'd5, 5'd11);
        chk("br5_taken", 32'(out_taken), 32'd1);
        chk("br5_result", out_result, 32'h100);
        issue(5'd15, 32'h100, 32'hFFFF_FFF0, '0, 3'd2, 5'd12);
        chk("br2_taken", 32'(out_taken), 32'd0);
        issue(5'd15, 32'h100, 32'hFFFF_FFF0, '0, 3'd7, 5'd13);
        chk("br7_taken", 32'(out_taken), 32'd0);
        issue(5'd0, 32'd1, 32'd1, '0, '0, 5'd14);
        chk("add_after_br_taken", 32'(out_taken), 32'd0);

        issue(5'd17, 32'd5, 32'd6, '0, '0, 5'd15);
        chk("ill17_result", out_result, 32'd0);
        chk("ill17_flag", 32'(out_illegal), 32'd1);
        issue(5'd31, 32'd5, 32'd6, '0, '0, 5'd16);
        chk("ill31_flag", 32'(out_illegal), 32'd1);
        issue(5'd4, 32'hFF, 32'h0F, '0, '0, 5'd17);
        chk("and_result", out_result, 32'h0F);
        chk("and_illegal", 32'(out_illegal), 32'd0);

        // Multiply: 7 * -3 = -21.
        issue(5'd16, 32'd7, 32'hFFFF_FFFD, '0, '0, 5'd21);
        IN_VALID = 1'b0;
        chk("nomul_valid", 32'(nm_out_valid), 32'd1);
        chk("nomul_illegal", 32'(nm_out_illegal), 32'd1);
        chk("nomul_result", nm_out_result, 32'd0);
        chk("mul_busy_0", 32'(busy), 32'd1);
        chk("mul_in_ready_0", 32'(in_ready), 32'd0);
        chk("mul_valid_0", 32'(out_valid), 32'd0);
        IN_VALID = 1'b1;
        IN_OP = 5'd0;
        for (int k = 1; k < 32; k++) begin
            tick;
            chk($sformatf("mul_busy_%0d", k), 32'(busy), 32'd1);
            chk($sformatf("mul_in_ready_%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("mul_valid_%0d", k), 32'(out_valid), 32'd0);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        tick;
        chk("mul_done_busy", 32'(busy), 32'd0);
        chk("mul_done_valid", 32'(out_valid), 32'd1);
        chk("mul_done_result", out_result, 32'hFFFF_FFEB);
        chk("mul_done_tag", 32'(out_tag), 32'd21);

        // Backpressure: result held, no new accept.
        IN_VALID = 1'b1;
        IN_OP = 5'd0; IN_A = 32'd1; IN_B = 32'd1; IN_TAG = 5'd2;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_result_%0d", k), out_result, 32'hFFFF_FFEB);
            chk($sformatf("bp_tag_%0d", k), 32'(out_tag), 32'd21);
        end
        OUT_READY = 1'b1;
        FLUSH = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick;
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_result", out_result, 32'd0);

        // Flush on the 10th edge of a multiply.
        issue(5'd16, 32'd7, 32'hFFFF_FFFD, '0, '0, 5'd22);
        IN_VALID = 1'b0;
        for (int k = 1; k < 10; k++) tick;
        chk("mflush_busy_pre", 32'(busy), 32'd1);
        FLUSH = 1'b1;
        tick;
        FLUSH = 1'b0;
        chk("mflush_busy", 32'(busy), 32'd0);
        chk("mflush_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 30; k++) begin
            tick;
            chk($sformatf("mflush_no_result_%0d", k), 32'(out_valid), 32'd0);
        end
        chk("mflush_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of a multiply.
        issue(5'd16, 32'd3, 32'd5, '0, '0, 5'd23);
        IN_VALID = 1'b0;
        for (int k = 0; k < 5; k++) tick;
        #2;
        RSTN = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        tick;
        RSTN = 1'b1;
        tick;
        chk("mrst_no_result", 32'(out_valid), 32'd0);

        // Reset clears a held, taken branch result.
        OUT_READY = 1'b0;
        issue(5'd15, 32'h1234, 32'd0, '0, 3'd1, 5'd19);
        IN_VALID = 1'b0;
        chk("hold_taken", 32'(out_taken), 32'd1);
        chk("hold_result", out_result, 32'h1234);
        #2;
        RSTN = 1'b0;
        #1;
        chk("hrst_valid", 32'(out_valid), 32'd0);
        chk("hrst_result", out_result, 32'd0);
        chk("hrst_taken", 32'(out_taken), 32'd0);
        chk("hrst_tag", 32'(out_tag), 32'd0);
        chk("hrst_illegal", 32'(out_illegal), 32'd0);
        tick;
        RSTN = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
